// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 capture path and the VGA read side.
// Holds the capture state encoding, RGB565 field layout and default frame geometry.
package ov7670_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      ACTIVE
   } cap_state_t;

   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   localparam int DEF_H_ACTIVE = 320;
   localparam int DEF_V_ACTIVE = 240;

   // The camera sends R[4:0]G[5:3] first and G[2:0]B[4:0] second.
   function automatic logic [15:0] rgb565_word(input logic [7:0] hi, input logic [7:0] lo);
      logic [15:0] w;
      w = '0;
      w[R_MSB:R_LSB] = hi[7:3];
      w[G_MSB:G_LSB] = {hi[2:0], lo[7:5]};
      w[B_MSB:B_LSB] = lo[4:0];
      return w;
   endfunction

endpackage

// File: rtl/ov7670_capture_rgb565_byte_pair.sv
// Pairs consecutive camera bytes into RGB565 words.
// Tracks the byte phase, latches the high byte and flags lines ending on an odd byte.
module rgb565_byte_pair
   import ov7670_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        en,
   input  logic        href,
   input  logic        href_fall,
   input  logic [7:0]  d,
   output logic        word_valid,
   output logic [15:0] word,
   output logic        odd_err,
   output logic        pending
);

   logic       phase;
   logic [7:0] hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= 1'b0;
         hi    <= '0;
      end else if (clear) begin
         phase <= 1'b0;
      end else if (en) begin
         if (href) begin
            if (!phase) begin
               hi    <= d;
               phase <= 1'b1;
            end else begin
               phase <= 1'b0;
            end
         end else begin
            phase <= 1'b0;
         end
      end
   end

   assign word_valid = en & href & phase;
   assign word       = rgb565_word(hi, d);
   assign odd_err    = en & href_fall & phase;
   assign pending    = phase;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 byte-stream capture: builds RGB565 words and writes them linearly to the frame buffer.
// Optional CAPTURE_DECIMATE_EN writes only every other frame and adds frame_skipped.
module ov7670_capture
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int ADDR_W   = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        d,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              frame_done,
   output logic              frame_err
`ifdef CAPTURE_DECIMATE_EN
   ,
   output logic              frame_skipped
`endif
);

   // state  | meaning
   // IDLE   | after reset, waiting for the first vsync rise
   // SYNC   | inside vertical sync, waiting for vsync fall
   // ACTIVE | capturing lines until the next vsync rise

   localparam logic [ADDR_W:0] TOTAL = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);

   cap_state_t state, state_nxt;

   logic              vsync_q, href_q, vsync_p, href_p;
   logic [7:0]        d_q;
   logic              vsync_rise, vsync_fall, href_fall;
   logic [ADDR_W:0]   count;
   logic              err_flag;
   logic              start_frame, end_frame;
   logic              pair_clear, pair_en;
   logic              word_valid, odd_err, pending;
   logic [15:0]       word;
   logic              frame_wr, write_now, full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         d_q     <= '0;
         vsync_p <= 1'b0;
         href_p  <= 1'b0;
      end else begin
         vsync_q <= vsync;
         href_q  <= href;
         d_q     <= d;
         vsync_p <= vsync_q;
         href_p  <= href_q;
      end
   end

   assign vsync_rise = vsync_q & ~vsync_p;
   assign vsync_fall = ~vsync_q & vsync_p;
   assign href_fall  = ~href_q & href_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      start_frame = 1'b0;
      end_frame   = 1'b0;
      pair_clear  = 1'b1;
      pair_en     = 1'b0;
      case (state)
         IDLE: begin
            if (vsync_rise) state_nxt = SYNC;
         end
         SYNC: begin
            if (vsync_fall) begin
               state_nxt   = ACTIVE;
               start_frame = 1'b1;
            end
         end
         ACTIVE: begin
            if (vsync_rise) begin
               state_nxt = SYNC;
               end_frame = 1'b1;
            end else begin
               pair_clear = 1'b0;
               pair_en    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   rgb565_byte_pair u_pair (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (pair_clear),
      .en         (pair_en),
      .href       (href_q),
      .href_fall  (href_fall),
      .d          (d_q),
      .word_valid (word_valid),
      .word       (word),
      .odd_err    (odd_err),
      .pending    (pending)
   );

`ifdef CAPTURE_DECIMATE_EN
   logic toggle;

   // Resets to 1 so the first frame after reset flips to 0 and is written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           toggle <= 1'b1;
      else if (start_frame) toggle <= ~toggle;
   end

   assign frame_wr = ~toggle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_skipped <= 1'b0;
      else        frame_skipped <= end_frame & toggle;
   end
`else
   assign frame_wr = 1'b1;
`endif

   assign full      = (count == TOTAL);
   assign write_now = word_valid & ~full & frame_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         err_flag <= 1'b0;
      end else if (start_frame) begin
         count    <= '0;
         err_flag <= 1'b0;
      end else begin
         if (word_valid && !full) count <= count + 1'b1;
         if ((word_valid && full) || odd_err) err_flag <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         wr_en      <= write_now;
         frame_done <= end_frame;
         // A vsync rise with a line still in flight drops whatever bytes are pending.
         frame_err  <= end_frame & (err_flag | href_q | pending | (count != TOTAL));
         if (write_now) begin
            wr_addr <= count[ADDR_W-1:0];
            wr_data <= word;
         end
      end
   end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture with a write/frame scoreboard on a 4x2 frame.
// Build with CAPTURE_DECIMATE_EN defined to also exercise frame decimation.
module tb_ov7670_capture;

   localparam int H = 4;
   localparam int V = 2;
   localparam int AW = 3;
   localparam int TOT = H * V;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vsync = 1'b0;
   logic          href = 1'b0;
   logic [7:0]    d = '0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          frame_done;
   logic          frame_err;
`ifdef CAPTURE_DECIMATE_EN
   logic          frame_skipped;
`endif

   int tests = 0;
   int fails = 0;

   logic [AW+15:0] wq[$];
   logic [1:0]     fq[$];
   logic [AW+15:0] wexp;
   logic [1:0]     fexp;
   int             exp_addr = 0;

   ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .vsync      (vsync),
      .href       (href),
      .d          (d),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .frame_err  (frame_err)
`ifdef CAPTURE_DECIMATE_EN
      ,
      .frame_skipped (frame_skipped)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         tests++;
         assert (wq.size() > 0) else begin
            fails++;
            $error("FAIL unexpected_write: addr=%0d data=%h, required no write", wr_addr, wr_data);
         end
         if (wq.size() > 0) begin
            wexp = wq.pop_front();
            tests++;
            assert ({wr_addr, wr_data} === wexp) else begin
               fails++;
               $error("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                      wr_addr, wr_data, wexp[AW+15:16], wexp[15:0]);
            end
         end
      end
      if (rst_n && frame_done) begin
         tests++;
         assert (fq.size() > 0) else begin
            fails++;
            $error("FAIL unexpected_frame_done: err=%0b, required no frame_done", frame_err);
         end
         if (fq.size() > 0) begin
            fexp = fq.pop_front();
            tests++;
            assert (frame_err === fexp[0]) else begin
               fails++;
               $error("FAIL frame_err: got %0b, required %0b", frame_err, fexp[0]);
            end
`ifdef CAPTURE_DECIMATE_EN
            tests++;
            assert (frame_skipped === fexp[1]) else begin
               fails++;
               $error("FAIL frame_skipped: got %0b, required %0b", frame_skipped, fexp[1]);
            end
`endif
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic vsync_pulse();
      @(negedge clk);
      vsync = 1'b1;
      href  = 1'b0;
      idle(3);
      vsync = 1'b0;
      idle(5);
      exp_addr = 0;
   endtask

   // n bytes starting at value s; pairs are expected as writes only when wr is set
   task automatic send_line(input int n, input int s, input bit wr);
      logic [7:0] hb;
      hb = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         href = 1'b1;
         d    = 8'(s + i);
         if (i % 2 == 0) begin
            hb = d;
         end else begin
            if (exp_addr < TOT) begin
               if (wr) wq.push_back({AW'(exp_addr), hb, d});
               exp_addr++;
            end
         end
      end
      @(negedge clk);
      href = 1'b0;
      idle(3);
   endtask

   task automatic check_zero(input string tag);
      tests++;
      assert ({wr_en, wr_addr, wr_data, frame_done, frame_err} === '0) else begin
         fails++;
         $error("FAIL %s: outputs=%h, required all zero", tag,
                {wr_en, wr_addr, wr_data, frame_done, frame_err});
      end
   endtask

   task automatic check_drained(input string tag);
      tests++;
      assert (wq.size() == 0 && fq.size() == 0) else begin
         fails++;
         $error("FAIL %s: pending writes=%0d frames=%0d, required 0 and 0", tag, wq.size(), fq.size());
      end
   endtask

   initial begin
      idle(3);
      check_zero("reset_outputs");
      tests++;
      assert (dut.state === ov7670_pkg::IDLE) else begin
         fails++;
         $error("FAIL reset_state: got %0d, required IDLE", dut.state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      send_line(8, 8'h40, 1'b0);
      check_drained("no_write_before_vsync");

      vsync_pulse();
      send_line(8, 8'h00, 1'b1);
      send_line(8, 8'h08, 1'b1);
      fq.push_back(2'b00);
      vsync_pulse();
      check_drained("good_frame");

      send_line(8, 8'h20, 1'b1);
      send_line(7, 8'h30, 1'b1);
      fq.push_back(2'b01);
      vsync_pulse();
      check_drained("odd_line_frame");

      send_line(8, 8'h50, 1'b1);
      send_line(8, 8'h60, 1'b1);
      send_line(8, 8'h70, 1'b1);
      fq.push_back(2'b01);
      vsync_pulse();
      check_drained("overflow_frame");

      send_line(6, 8'h80, 1'b1);
      idle(2);
      check_drained("three_writes_before_reset");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("mid_frame_reset");
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      vsync_pulse();
      send_line(8, 8'h90, 1'b1);
      send_line(8, 8'hA0, 1'b1);
      fq.push_back(2'b00);
      vsync_pulse();
      check_drained("frame_after_reset");

      send_line(8, 8'hB0, 1'b1);
      vsync = 1'b0;
      @(negedge clk);
      href = 1'b1;
      d    = 8'hC0;
      @(negedge clk);
      fq.push_back(2'b01);
      vsync = 1'b1;
      d     = 8'hC1;
      @(negedge clk);
      href  = 1'b0;
      idle(3);
      vsync = 1'b0;
      idle(5);
      exp_addr = 0;
      check_drained("vsync_during_href");

`ifdef CAPTURE_DECIMATE_EN
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      vsync_pulse();
      for (int f = 0; f < 4; f++) begin
         send_line(8, 16 * f, f % 2 == 0);
         send_line(8, 16 * f + 8, f % 2 == 0);
         fq.push_back({1'(f % 2), 1'b0});
         vsync_pulse();
      end
      check_drained("decimated_frames");
`endif

      idle(4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
